demultiplexer4x4_buf: RTL

Buffered 4-bit 1-to-4 demultiplexer, the distribution-side counterpart of the team's 4-bit 4-to-1 multiplexer. It accepts 4-bit words on a valid/ready input handshake and routes each word into one of four single-entry output holding registers. The target is chosen either by an explicit 2-bit select or by an internal round-robin pointer. Each output channel holds its word and a valid flag until the downstream consumer acknowledges it.

---
 rtl/demultiplexer4x4_buf.sv | 64 ++++++
 1 files changed

// File: rtl/demultiplexer4x4_buf.sv
// Buffered 4-bit 1-to-4 demultiplexer. Each word on the valid/ready input is routed into one of
// four single-entry holding registers, chosen by sel (addressed) or by a round-robin pointer.
module demultiplexer4x4_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] sel,
  input  logic       mode,
  input  logic [3:0] ack,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [3:0] v,
  output logic [1:0] ptr,
  output logic [7:0] cnt
);

  logic [3:0] ybuf [4];
  logic [1:0] tgt;
  logic       acc;

  // A full target that is being acked this cycle is free again, so it can be refilled without a bubble.
  always_comb begin
    tgt      = mode ? ptr : sel;
    in_ready = ~v[tgt] | ack[tgt];
    acc      = in_valid & in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ybuf[i] <= 4'h0;
      end
      v   <= 4'b0000;
      ptr <= 2'd0;
      cnt <= 8'd0;
    end else begin
      // The incoming word takes priority over an ack on the same channel.
      for (int i = 0; i < 4; i++) begin
        if (acc && (tgt == 2'(i))) begin
          ybuf[i] <= din;
          v[i]    <= 1'b1;
        end else if (ack[i]) begin
          v[i] <= 1'b0;
        end
      end
      if (acc) begin
        cnt <= cnt + 8'd1;
        if (mode) begin
          ptr <= ptr + 2'd1;
        end
      end
    end
  end

  assign y0 = ybuf[0];
  assign y1 = ybuf[1];
  assign y2 = ybuf[2];
  assign y3 = ybuf[3];

endmodule
